// File: rtl/wb_select_stage.sv
// Register-file writeback stage: picks one of NSRC result sources per instruction,
// stalls on load data when the memory source is selected, and keeps the last write for bypass.
module wb_select_stage #(
    parameter int D       = 8,
    parameter int NSRC    = 4,
    parameter int AW      = 3,
    parameter int MEM_IDX = 1,
    parameter int TIMEOUT = 16,
    localparam int SW     = $clog2(NSRC)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NSRC*D-1:0] src_dat,
    input  logic [SW-1:0]     src_sel,
    input  logic              wr_en_in,
    input  logic [AW-1:0]     wr_addr_in,
    input  logic              mem_valid,
    input  logic [D-1:0]      mem_dat,
    output logic              rf_we,
    output logic [AW-1:0]     rf_waddr,
    output logic [D-1:0]      rf_wdat,
    output logic              fwd_valid,
    output logic [AW-1:0]     fwd_addr,
    output logic [D-1:0]      fwd_dat,
    output logic              err
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic {IDLE, WAIT_MEM} state_t;

    state_t          state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [AW-1:0]   pend_addr_reg, pend_addr_next;
    logic            err_next;

    logic [D-1:0]    src_word [NSRC];
    logic [D-1:0]    sel_data;
    logic            mem_sel;
    logic            accept;
    logic            wr_fire;
    logic [AW-1:0]   wr_addr_sel;
    logic [D-1:0]    wr_dat_sel;

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            assign src_word[gi] = src_dat[gi*D +: D];
        end
    endgenerate

    // Out-of-range selects match no entry and fall back to source 0.
    always_comb begin
        sel_data = src_word[0];
        for (int k = 1; k < NSRC; k++) begin
            if (src_sel == SW'(k)) begin
                sel_data = src_word[k];
            end
        end
    end

    assign mem_sel  = (src_sel == SW'(MEM_IDX));
    assign in_ready = (state_reg == IDLE);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        pend_addr_next = pend_addr_reg;
        err_next       = err_reg_q();
        wr_fire        = 1'b0;
        wr_addr_sel    = wr_addr_in;
        wr_dat_sel     = sel_data;
        case (state_reg)
            IDLE: begin
                if (accept && wr_en_in) begin
                    if (!mem_sel) begin
                        wr_fire = 1'b1;
                    end else if (mem_valid) begin
                        wr_fire    = 1'b1;
                        wr_dat_sel = mem_dat;
                    end else begin
                        state_next     = WAIT_MEM;
                        pend_addr_next = wr_addr_in;
                        cnt_next       = '0;
                    end
                end
            end
            WAIT_MEM: begin
                // Load data arriving on the timeout cycle still wins.
                if (mem_valid) begin
                    wr_fire     = 1'b1;
                    wr_addr_sel = pend_addr_reg;
                    wr_dat_sel  = mem_dat;
                    state_next  = IDLE;
                end else if ((TIMEOUT != 0) && (cnt_reg == CNT_LAST)) begin
                    err_next   = 1'b1;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt_reg + CW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    function automatic logic err_reg_q();
        return err;
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            pend_addr_reg <= '0;
            err           <= 1'b0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            pend_addr_reg <= pend_addr_next;
            err           <= err_next;
        end
    end

    // rf_* and fwd_* load on the same edge so they agree whenever rf_we is high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we     <= 1'b0;
            rf_waddr  <= '0;
            rf_wdat   <= '0;
            fwd_valid <= 1'b0;
            fwd_addr  <= '0;
            fwd_dat   <= '0;
        end else begin
            rf_we <= wr_fire;
            if (wr_fire) begin
                rf_waddr  <= wr_addr_sel;
                rf_wdat   <= wr_dat_sel;
                fwd_valid <= 1'b1;
                fwd_addr  <= wr_addr_sel;
                fwd_dat   <= wr_dat_sel;
            end
        end
    end

endmodule

// File: tb/tb_wb_select_stage.sv
// Self-checking bench for wb_select_stage: vector table for single-cycle writes,
// hand sequences for load stalls, timeout and mid-wait reset; writes checked via a scoreboard.
module tb_wb_select_stage;

    localparam int D       = 8;
    localparam int NSRC    = 5;
    localparam int AW      = 3;
    localparam int MEM_IDX = 1;
    localparam int TIMEOUT = 16;
    localparam int SW      = $clog2(NSRC);

    logic              clk;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [NSRC*D-1:0] src_dat;
    logic [SW-1:0]     src_sel;
    logic              wr_en_in;
    logic [AW-1:0]     wr_addr_in;
    logic              mem_valid;
    logic [D-1:0]      mem_dat;
    logic              rf_we;
    logic [AW-1:0]     rf_waddr;
    logic [D-1:0]      rf_wdat;
    logic              fwd_valid;
    logic [AW-1:0]     fwd_addr;
    logic [D-1:0]      fwd_dat;
    logic              err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [SW-1:0] sel;
        logic [AW-1:0] addr;
        logic          wr_en;
        logic          mv;
        logic [D-1:0]  md;
        logic          exp_we;
        logic [AW-1:0] exp_addr;
        logic [D-1:0]  exp_dat;
    } vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [D-1:0]  dat;
    } wr_t;

    wr_t  exp_q[$];
    vec_t vecs[10];

    wb_select_stage #(
        .D(D), .NSRC(NSRC), .AW(AW), .MEM_IDX(MEM_IDX), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .src_dat(src_dat), .src_sel(src_sel),
        .wr_en_in(wr_en_in), .wr_addr_in(wr_addr_in),
        .mem_valid(mem_valid), .mem_dat(mem_dat),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdat(rf_wdat),
        .fwd_valid(fwd_valid), .fwd_addr(fwd_addr), .fwd_dat(fwd_dat),
        .err(err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_rf_we"},     32'(rf_we),     0);
        check({tag, "_rf_waddr"},  32'(rf_waddr),  0);
        check({tag, "_rf_wdat"},   32'(rf_wdat),   0);
        check({tag, "_fwd_valid"}, 32'(fwd_valid), 0);
        check({tag, "_fwd_addr"},  32'(fwd_addr),  0);
        check({tag, "_fwd_dat"},   32'(fwd_dat),   0);
        check({tag, "_err"},       32'(err),       0);
        check({tag, "_in_ready"},  32'(in_ready),  1);
    endtask

    task automatic push_exp(input logic [AW-1:0] a, input logic [D-1:0] d);
        wr_t w;
        w.addr = a;
        w.dat  = d;
        exp_q.push_back(w);
    endtask

    task automatic start_load(input logic [AW-1:0] a);
        in_valid   = 1'b1;
        src_sel    = SW'(MEM_IDX);
        wr_addr_in = a;
        wr_en_in   = 1'b1;
        mem_valid  = 1'b0;
        tick();
        in_valid   = 1'b0;
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (rf_we === 1'b1) begin
            $display("write addr=%0d dat=0x%0h", rf_waddr, rf_wdat);
            check("write_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                wr_t w;
                w = exp_q.pop_front();
                check("wr_addr", 32'(rf_waddr), 32'(w.addr));
                check("wr_dat", 32'(rf_wdat), 32'(w.dat));
                check("fwd_valid", 32'(fwd_valid), 1);
                check("fwd_addr", 32'(fwd_addr), 32'(w.addr));
                check("fwd_dat", 32'(fwd_dat), 32'(w.dat));
            end
        end
    end

    initial begin
        // Sources 0..4 = 11,22,33,44,55; slot 1 is the memory source and must be ignored.
        vecs[0] = '{3'd0, 3'd3, 1'b1, 1'b0, 8'h00, 1'b1, 3'd3, 8'h11};
        vecs[1] = '{3'd0, 3'd1, 1'b1, 1'b0, 8'h00, 1'b1, 3'd1, 8'h11};
        vecs[2] = '{3'd2, 3'd2, 1'b1, 1'b0, 8'h00, 1'b1, 3'd2, 8'h33};
        vecs[3] = '{3'd3, 3'd4, 1'b1, 1'b0, 8'h00, 1'b1, 3'd4, 8'h44};
        vecs[4] = '{3'd5, 3'd6, 1'b1, 1'b0, 8'h00, 1'b1, 3'd6, 8'h11};
        vecs[5] = '{3'd4, 3'd7, 1'b1, 1'b0, 8'h00, 1'b1, 3'd7, 8'h55};
        vecs[6] = '{3'd2, 3'd5, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 8'h00};
        vecs[7] = '{3'd1, 3'd2, 1'b1, 1'b1, 8'h3C, 1'b1, 3'd2, 8'h3C};
        vecs[8] = '{3'd1, 3'd0, 1'b0, 1'b1, 8'h99, 1'b0, 3'd0, 8'h00};
        vecs[9] = '{3'd7, 3'd5, 1'b1, 1'b0, 8'h00, 1'b1, 3'd5, 8'h11};

        reset      = 1'b1;
        in_valid   = 1'b0;
        src_sel    = '0;
        wr_en_in   = 1'b0;
        wr_addr_in = '0;
        mem_valid  = 1'b0;
        mem_dat    = '0;
        src_dat    = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};

        tick();
        check_reset_values("reset");
        tick();
        reset = 1'b0;
        tick();

        // Back-to-back single-cycle accepts; in_ready must never drop.
        for (int i = 0; i < 10; i++) begin
            check("vec_in_ready", 32'(in_ready), 1);
            in_valid   = 1'b1;
            src_sel    = vecs[i].sel;
            wr_addr_in = vecs[i].addr;
            wr_en_in   = vecs[i].wr_en;
            mem_valid  = vecs[i].mv;
            mem_dat    = vecs[i].md;
            if (vecs[i].exp_we) push_exp(vecs[i].exp_addr, vecs[i].exp_dat);
            tick();
        end
        in_valid  = 1'b0;
        mem_valid = 1'b0;
        tick();

        // mem_valid with nothing pending must be ignored.
        mem_valid = 1'b1;
        mem_dat   = 8'hEE;
        tick();
        mem_valid = 1'b0;
        tick();

        // Stalled load: data arrives three cycles after accept.
        start_load(3'd5);
        check("stall_ready_1", 32'(in_ready), 0);
        tick();
        check("stall_ready_2", 32'(in_ready), 0);
        tick();
        check("stall_ready_3", 32'(in_ready), 0);
        mem_valid = 1'b1;
        mem_dat   = 8'hA5;
        push_exp(3'd5, 8'hA5);
        tick();
        mem_valid = 1'b0;
        check("stall_ready_after", 32'(in_ready), 1);
        check("stall_rf_we", 32'(rf_we), 1);
        tick();
        check("stall_we_pulse", 32'(rf_we), 0);
        check("stall_hold_addr", 32'(rf_waddr), 5);
        check("stall_hold_dat", 32'(rf_wdat), 32'h A5);

        // Load data on the final permitted cycle still commits, no error.
        start_load(3'd4);
        repeat (TIMEOUT - 1) tick();
        check("edge_wait_ready", 32'(in_ready), 0);
        mem_valid = 1'b1;
        mem_dat   = 8'h5A;
        push_exp(3'd4, 8'h5A);
        tick();
        mem_valid = 1'b0;
        check("edge_err", 32'(err), 0);
        check("edge_ready", 32'(in_ready), 1);
        check("edge_rf_we", 32'(rf_we), 1);
        tick();

        // Timeout: no load data at all.
        start_load(3'd6);
        for (int k = 1; k <= TIMEOUT; k++) begin
            check("to_err_low", 32'(err), 0);
            check("to_ready_low", 32'(in_ready), 0);
            tick();
        end
        check("to_err_high", 32'(err), 1);
        check("to_ready_back", 32'(in_ready), 1);
        check("to_fwd_addr", 32'(fwd_addr), 4);
        check("to_fwd_dat", 32'(fwd_dat), 32'h5A);
        check("to_fwd_valid", 32'(fwd_valid), 1);
        in_valid   = 1'b1;
        src_sel    = SW'(MEM_IDX);
        wr_addr_in = 3'd1;
        wr_en_in   = 1'b0;
        tick();
        in_valid = 1'b0;
        check("bubble_ready", 32'(in_ready), 1);
        tick();
        tick();
        check("err_sticky", 32'(err), 1);

        // Reset in the middle of a wait discards the pending load.
        start_load(3'd3);
        tick();
        reset = 1'b1;
        #1;
        check("async_rst_ready", 32'(in_ready), 1);
        check("async_rst_err", 32'(err), 0);
        tick();
        reset     = 1'b0;
        mem_valid = 1'b1;
        mem_dat   = 8'h77;
        tick();
        mem_valid = 1'b0;
        tick();
        check_reset_values("midrst");

        check("queue_empty", 32'(exp_q.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
